// File: rtl/pe_idx_loader.sv
// Streams one batch of index words into the AGU index buffer, then swaps banks and starts the PE AGU.
// Writes land 1 cycle after acceptance; the bank swap waits until the AGU reports idle.
`timescale 1ns/1ps
module pe_idx_loader #(
  parameter int IDX_W      = 8,
  parameter int IDX_DEPTH  = 256,
  parameter int IDX_ADDR_W = $clog2(IDX_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [23:0]           cmd_info,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*IDX_W-1:0]    in_data,
  output logic [IDX_ADDR_W-1:0] idx_wr_addr,
  output logic [2*IDX_W-1:0]    idx_wr_data,
  output logic                  idx_wr_en,
  output logic                  switch_idx_buf,
  output logic                  agu_start,
  output logic [23:0]           agu_info,
  input  logic                  agu_done
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, SWITCH, START} state_t;

  state_t      state, next_state;
  logic [23:0] pending;
  logic [7:0]  wr_cnt;
  logic [1:0]  holdoff;
  logic        cmd_acc, in_acc;

  // Handshake readiness depends on state only; reset forces everything quiet.
  assign cmd_ready      = !rst && (state == IDLE);
  assign in_ready       = !rst && (state == LOAD);
  assign switch_idx_buf = !rst && (state == SWITCH);
  assign agu_start      = !rst && (state == START);

  assign cmd_acc = cmd_valid && cmd_ready;
  assign in_acc  = in_valid && in_ready;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_acc) next_state = (cmd_info[9:2] == 8'd0) ? WAIT : LOAD;
      LOAD:    if (in_acc && (wr_cnt == pending[9:2] - 8'd1)) next_state = WAIT;
      WAIT:    if (agu_done && (holdoff == 2'd0)) next_state = SWITCH;
      SWITCH:  next_state = START;
      START:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      wr_cnt      <= '0;
      holdoff     <= '0;
      agu_info    <= '0;
      idx_wr_en   <= 1'b0;
      idx_wr_addr <= '0;
      idx_wr_data <= '0;
    end else begin
      state     <= next_state;
      idx_wr_en <= in_acc;
      if (cmd_acc) begin
        pending <= cmd_info;
        wr_cnt  <= '0;
      end
      if (in_acc) begin
        idx_wr_addr <= IDX_ADDR_W'(wr_cnt);
        idx_wr_data <= in_data;
        wr_cnt      <= wr_cnt + 8'd1;
      end
      // Loaded a cycle early so agu_info is already valid while agu_start is high.
      if (state == SWITCH) agu_info <= pending;
      // The AGU's done flag drops a cycle after start; ignore it until then.
      if (state == START) holdoff <= 2'd2;
      else if (holdoff != 2'd0) holdoff <= holdoff - 2'd1;
    end
  end

endmodule
